page_order_arbiter: RTL and testbench
=====================================

# page_order_arbiter

Grants the shared downstream output port to the parsers in the same order that pages were dispatched to them, so decompressed output leaves the parser array in original stream order. Sits beside the page distributor: it records each dispatch (parser index) in an order FIFO, back-pressures the distributor when that FIFO nears full, and sequences per-page output bursts from the parsers to the downstream writer.

## Interface
- NUM_PARSER, 6, number of parsers; one-hot width of select/grant vectors
- DEPTH, 16, order-FIFO entries; power of two, ≥4
- IDX_W, $clog2(NUM_PARSER), stored parser-index width (derived, not overridden)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- dispatch_valid  in  1  distributor accepted a page this cycle (its rdreq)
- dispatch_sel  in  NUM_PARSER  one-hot target parser of that page (its valid_out)
- stop_out  out  1  back-pressure to distributor stop input
- parser_req  in  NUM_PARSER  parser i holds an output beat
- parser_last  in  NUM_PARSER  parser i's current beat is last of its page
- out_ready  in  1  downstream accepts a beat
- grant  out  NUM_PARSER  one-hot owner of the output port, registered
- beat_fire  out  1  grant&parser_req&out_ready nonzero this cycle
- order_empty  out  1  no pages outstanding
- err  out  1  sticky: overflow or non-one-hot dispatch_sel

## Operation
- Push: dispatch_valid=1 with one-hot dispatch_sel encodes index, pushes. Non-one-hot (zero or multi-bit): no push, err set.
- Push while count==DEPTH: dropped, err set. stop_out = (count ≥ DEPTH-2); margin covers distributor's one-cycle registered stop.
- States: IDLE (FIFO empty), WAIT (head parser not requesting), XFER (grant asserted).
- IDLE→WAIT when count becomes nonzero. WAIT→XFER when parser_req[head]=1; grant<=onehot(head) on that edge.
- XFER: beat transfers on parser_req[head]&out_ready. Transfer with parser_last[head]=1 pops FIFO, clears grant; next state WAIT if remaining count>0 else IDLE.
- Requests from non-head parsers are ignored; they hold until their page reaches head.
- Simultaneous push and pop: both take effect, count unchanged.
- err clears only on reset.

## Timing
- Reset (async assert, sync release): state IDLE, count 0, pointers 0, grant 0, stop_out 0, order_empty 1, err 0, beat_fire 0.
- Push visible in count/order_empty the next cycle; stop_out is combinational from count.
- WAIT→grant: 1 cycle after parser_req[head] seen in WAIT. If head already requesting on push, grant appears 2 cycles after dispatch.
- Last beat in cycle N: grant 0 in N+1 (one bubble); next grant earliest N+2.
- beat_fire combinational from registered grant; single-beat pages legal (req&last in first XFER cycle).
- Reset mid-burst: grant drops immediately; outstanding order entries discarded.

## Configuration
- PAGE_ORDER_ARBITER_STATS_EN defined: adds outputs stat_pages[31:0] (pages completed, wraps) and stat_stall[31:0] (cycles in WAIT with parser_req nonzero but parser_req[head]=0, saturating); both reset to 0.
- Undefined: ports still present, tied 0; no counter logic.

## Structure
- Package page_order_pkg: state enum (IDLE, WAIT, XFER), onehot-to-index function, stats width constant.
- One sub-module: page_order_fifo (sync FIFO, IDX_W wide, DEPTH deep, count output, simultaneous push/pop).

## Test plan
- Dispatch parsers 0,2,1; parsers 1 and 2 request first -> grant order 0b001, 0b100, 0b010; each page 3 beats, 9 beat_fire total.
- Single-beat pages back-to-back to parser 3, out_ready=1 -> grant 0b1000 pulses with one-cycle gap; order_empty=1 after last.
- out_ready low 5 cycles mid-burst -> grant held, beat_fire 0, no pop.
- Push 14 entries no pops -> stop_out=1 at count 14; push 3 more -> count 16, 17th dropped, err=1.
- dispatch_sel=0b000011 with dispatch_valid -> no push, err=1, count unchanged.
- Assert rst_n low during XFER -> grant=0 and order_empty=1 without waiting for clk edge.

Source files
------------

// File: rtl/page_order_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : page_order_pkg
// Description : Shared types and helpers for the page order arbiter:
//               arbiter state enum, one-hot helpers, statistics width.
// Revision    : 1.0  initial release
// ============================================================================
package page_order_pkg;

   // Arbiter states: nothing outstanding, waiting on head parser, bursting
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      XFER = 2'd2
   } state_t;

   // Width of the optional statistics counters
   localparam int STAT_W = 32;

   // Widest select vector the helpers accept
   localparam int VEC_MAX = 32;

   // Encode a one-hot vector into a bit index (OR of set positions)
   function automatic int onehot_to_idx(input logic [VEC_MAX-1:0] vec);
      int idx;
      idx = 0;
      for (int i = 0; i < VEC_MAX; i++) begin
         if (vec[i]) begin
            idx = idx | i;
         end
      end
      return idx;
   endfunction

   // True when exactly one bit of the vector is set
   function automatic logic is_onehot(input logic [VEC_MAX-1:0] vec);
      return (vec != '0) && ((vec & (vec - VEC_MAX'(1))) == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/page_order_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module      : page_order_fifo
// Description : Synchronous FIFO holding the parser index of every
//               dispatched page. Push while full and pop while empty are
//               ignored; simultaneous push and pop leave count unchanged.
// Revision    : 1.0  initial release
// ============================================================================
module page_order_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign head_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset since pointers qualify them
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/page_order_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : page_order_arbiter
// Description : Grants the shared output port to parsers in page dispatch
//               order. Dispatches are recorded in an order FIFO; the head
//               entry owns the port until its last beat transfers.
//               Optional statistics: define PAGE_ORDER_ARBITER_STATS_EN to
//               enable stat_pages / stat_stall (tied to zero otherwise).
// Revision    : 1.0  initial release
// ============================================================================
module page_order_arbiter
   import page_order_pkg::*;
#(
   parameter int NUM_PARSER = 6,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dispatch_valid,
   input  logic [NUM_PARSER-1:0] dispatch_sel,
   output logic                  stop_out,
   input  logic [NUM_PARSER-1:0] parser_req,
   input  logic [NUM_PARSER-1:0] parser_last,
   input  logic                  out_ready,
   output logic [NUM_PARSER-1:0] grant,
   output logic                  beat_fire,
   output logic                  order_empty,
   output logic                  err,
   output logic [STAT_W-1:0]     stat_pages,
   output logic [STAT_W-1:0]     stat_stall
);

   localparam int IDX_W = (NUM_PARSER > 1) ? $clog2(NUM_PARSER) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   state_t                state;
   state_t                state_nxt;
   logic [NUM_PARSER-1:0] grant_nxt;

   logic [VEC_MAX-1:0]    sel_wide;
   logic                  sel_ok;
   logic [IDX_W-1:0]      sel_idx;
   logic                  push_en;
   logic                  pop_en;

   logic [IDX_W-1:0]      head_idx;
   logic [CNT_W-1:0]      count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  head_req;
   logic                  head_last;
   logic [NUM_PARSER-1:0] head_onehot;
   logic                  more_after_pop;

   // ---------------------------------------------------------------------
   // Dispatch decode
   // ---------------------------------------------------------------------
   assign sel_wide = VEC_MAX'(dispatch_sel);
   assign sel_ok   = is_onehot(sel_wide);
   assign sel_idx  = IDX_W'(onehot_to_idx(sel_wide));
   assign push_en  = dispatch_valid & sel_ok & ~fifo_full;

   page_order_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_en),
      .push_data (sel_idx),
      .pop       (pop_en),
      .head_data (head_idx),
      .count     (count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // ---------------------------------------------------------------------
   // Head parser view and beat transfer
   // ---------------------------------------------------------------------
   assign head_req    = parser_req[head_idx];
   assign head_last   = parser_last[head_idx];
   assign head_onehot = NUM_PARSER'(1) << head_idx;

   // grant is only ever the head's one-hot, so this is the head's beat
   assign beat_fire   = (|(grant & parser_req)) & out_ready;
   assign pop_en      = beat_fire & head_last & (state == XFER);

   // Entries left once the head pops, counting a same-cycle push
   assign more_after_pop = (count != CNT_W'(1)) | push_en;

   // Two-entry margin absorbs the distributor's registered stop
   assign stop_out    = (count >= CNT_W'(DEPTH - 2));
   assign order_empty = fifo_empty;

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   // State and grant registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
      end
   end

   // Next-state decision
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (push_en || (count != '0)) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (head_req) begin
               state_nxt = XFER;
            end
         end
         XFER: begin
            if (pop_en) begin
               state_nxt = more_after_pop ? WAIT : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant follows the head whenever the next state is a transfer
   always_comb begin
      grant_nxt = '0;
      if (state_nxt == XFER) begin
         grant_nxt = head_onehot;
      end
   end

   // Sticky error: malformed select or push into a full order FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (dispatch_valid && (!sel_ok || fifo_full)) begin
         err <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Optional statistics
   // ---------------------------------------------------------------------
`ifdef PAGE_ORDER_ARBITER_STATS_EN
   logic [STAT_W-1:0] pages_cnt;
   logic [STAT_W-1:0] stall_cnt;

   // Completed pages (wrapping) and head-blocked stall cycles (saturating)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pages_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop_en) begin
            pages_cnt <= pages_cnt + STAT_W'(1);
         end
         if ((state == WAIT) && (|parser_req) && !head_req && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STAT_W'(1);
         end
      end
   end

   assign stat_pages = pages_cnt;
   assign stat_stall = stall_cnt;
`else
   assign stat_pages = '0;
   assign stat_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_page_order_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_page_order_arbiter
// Description : Self-checking bench for page_order_arbiter: directed
//               latency/boundary cases plus a randomized scoreboard run
//               against a queue-based model of page dispatch order.
// Revision    : 1.0  initial release
// ============================================================================
module tb_page_order_arbiter;

   localparam int NP    = 6;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          dispatch_valid = 1'b0;
   logic [NP-1:0] dispatch_sel = '0;
   logic [NP-1:0] parser_req = '0;
   logic [NP-1:0] parser_last = '0;
   logic          out_ready = 1'b0;
   logic          stop_out;
   logic [NP-1:0] grant;
   logic          beat_fire;
   logic          order_empty;
   logic          err;
   logic [31:0]   stat_pages;
   logic [31:0]   stat_stall;

   always #5 clk = ~clk;

   page_order_arbiter #(
      .NUM_PARSER (NP),
      .DEPTH      (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .dispatch_valid (dispatch_valid),
      .dispatch_sel   (dispatch_sel),
      .stop_out       (stop_out),
      .parser_req     (parser_req),
      .parser_last    (parser_last),
      .out_ready      (out_ready),
      .grant          (grant),
      .beat_fire      (beat_fire),
      .order_empty    (order_empty),
      .err            (err),
      .stat_pages     (stat_pages),
      .stat_stall     (stat_stall)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model: outstanding pages in dispatch order, beats remaining
   typedef struct {
      int idx;
      int rem;
   } page_t;
   page_t pages[$];
   int    exp_q[$];      // expected port owner for every future beat
   int    model_cnt = 0; // pages the DUT should be holding
   bit    mon_en = 1'b0;
   int    hold = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      dispatch_valid = 1'b0;
      dispatch_sel   = '0;
      parser_req     = '0;
      parser_last    = '0;
      out_ready      = 1'b0;
      rst_n          = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pages.delete();
      exp_q.delete();
      model_cnt = 0;
      hold = 0;
   endtask

   task automatic push_sel(input logic [NP-1:0] sel);
      @(posedge clk); #1;
      dispatch_valid = 1'b1;
      dispatch_sel   = sel;
      @(posedge clk); #1;
      dispatch_valid = 1'b0;
      dispatch_sel   = '0;
   endtask

   // Scoreboard monitor: compares every presented beat against the model
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         check("order_empty", order_empty, model_cnt == 0);
         check("stop_out", stop_out, model_cnt >= DEPTH - 2);
         check("beat_fire", beat_fire, (|(grant & parser_req)) & out_ready);
         if (beat_fire) begin
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL beat_unexpected: got grant %b expected no beat", grant);
            end else begin
               int e;
               e = exp_q.pop_front();
               check("grant_order", grant, NP'(1) << e);
            end
         end
      end
   end

   // One randomized cycle: retire what fired, then drive fresh inputs
   task automatic drive_cycle(input bit allow_disp);
      bit fire;
      int fidx;
      bit done;
      @(negedge clk);
      fire = beat_fire;
      fidx = -1;
      for (int i = 0; i < NP; i++) if (grant[i]) fidx = i;
      @(posedge clk); #1;
      if (dispatch_valid) model_cnt++;
      if (fire && fidx >= 0) begin
         done = 1'b0;
         for (int k = 0; k < pages.size(); k++) begin
            if (!done && pages[k].idx == fidx) begin
               done = 1'b1;
               pages[k].rem--;
               if (pages[k].rem == 0) begin
                  pages.delete(k);
                  model_cnt--;
               end
            end
         end
      end
      dispatch_valid = 1'b0;
      dispatch_sel   = '0;
      if (allow_disp && !stop_out && ($urandom_range(0, 99) < 45)) begin
         int p;
         int len;
         p   = $urandom_range(0, NP - 1);
         len = $urandom_range(1, 4);
         pages.push_back('{idx: p, rem: len});
         for (int b = 0; b < len; b++) exp_q.push_back(p);
         dispatch_valid = 1'b1;
         dispatch_sel   = NP'(1) << p;
      end
      for (int i = 0; i < NP; i++) begin
         int r;
         bit found;
         r = 0;
         found = 1'b0;
         for (int k = 0; k < pages.size(); k++) begin
            if (!found && pages[k].idx == i) begin
               found = 1'b1;
               r = pages[k].rem;
            end
         end
         parser_req[i]  = (r > 0) && ($urandom_range(0, 3) != 0);
         parser_last[i] = (r == 1);
      end
      if (hold > 0) begin
         out_ready = 1'b0;
         hold--;
      end else if ($urandom_range(0, 49) == 0) begin
         out_ready = 1'b0;
         hold = 4;
      end else begin
         out_ready = ($urandom_range(0, 4) != 0);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bit drained;

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_stop_out", stop_out, 0);
      check("rst_order_empty", order_empty, 1);
      check("rst_err", err, 0);
      check("rst_beat_fire", beat_fire, 0);
      check("rst_stat_pages", stat_pages, 0);
      check("rst_stat_stall", stat_stall, 0);

      // Back-to-back single-beat pages to parser 3, then reset mid-burst
      @(posedge clk); #1;
      dispatch_valid = 1'b1;
      dispatch_sel   = 6'b001000;
      parser_req     = 6'b001000;
      parser_last    = 6'b001000;
      out_ready      = 1'b1;
      @(negedge clk);
      check("lat_c0_grant", grant, 0);
      check("lat_c0_empty", order_empty, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_c1_grant", grant, 0);
      check("lat_c1_empty", order_empty, 0);
      @(posedge clk); #1;
      dispatch_valid = 1'b0;
      dispatch_sel   = '0;
      @(negedge clk);
      check("lat_c2_grant", grant, 6'b001000);
      check("lat_c2_fire", beat_fire, 1);
      @(negedge clk);
      check("lat_c3_bubble", grant, 0);
      check("lat_c3_fire", beat_fire, 0);
      @(negedge clk);
      check("lat_c4_grant", grant, 6'b001000);
      check("lat_c4_empty", order_empty, 0);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_grant", grant, 0);
      check("async_rst_empty", order_empty, 1);
      do_reset();

      // Fill to the stop threshold and past full
      for (int i = 0; i < 13; i++) push_sel(6'b000001);
      @(negedge clk);
      check("fill13_stop", stop_out, 0);
      push_sel(6'b000001);
      @(negedge clk);
      check("fill14_stop", stop_out, 1);
      push_sel(6'b000001);
      push_sel(6'b000001);
      @(negedge clk);
      check("fill16_err", err, 0);
      push_sel(6'b000001);
      @(negedge clk);
      check("overflow_err", err, 1);
      check("overflow_stop", stop_out, 1);
      @(posedge clk); #1;
      parser_req  = 6'b000001;
      parser_last = 6'b000001;
      out_ready   = 1'b1;
      n = 0;
      for (int c = 0; c < 200 && !order_empty; c++) begin
         @(negedge clk);
         if (beat_fire) n++;
      end
      check("overflow_drained_pages", n, 16);
      check("overflow_drain_empty", order_empty, 1);
      do_reset();

      // Malformed selects: no push, sticky error
      push_sel(6'b000010);
      push_sel(6'b000010);
      push_sel(6'b000011);
      @(negedge clk);
      check("multi_sel_err", err, 1);
      for (int i = 0; i < 11; i++) push_sel(6'b000010);
      @(negedge clk);
      check("multi_sel_count13_stop", stop_out, 0);
      push_sel(6'b000010);
      @(negedge clk);
      check("multi_sel_count14_stop", stop_out, 1);
      check("err_sticky", err, 1);
      do_reset();
      push_sel(6'b000000);
      @(negedge clk);
      check("zero_sel_err", err, 1);
      check("zero_sel_empty", order_empty, 1);
      do_reset();

      // Randomized run with scoreboard
      mon_en = 1'b1;
      for (int c = 0; c < 3000; c++) drive_cycle(1'b1);
      drained = 1'b0;
      for (int c = 0; c < 3000 && !drained; c++) begin
         drive_cycle(1'b0);
         if (exp_q.size() == 0 && model_cnt == 0) drained = 1'b1;
      end
      mon_en = 1'b0;
      if (!drained) begin
         total_cnt++;
         $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
      end
      @(negedge clk);
      check("final_empty", order_empty, 1);
      check("final_grant", grant, 0);
      check("final_err", err, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
